// File: rtl/roi28x28_frame_reader.sv
// Streams a W x H row-major ROI buffer to the CNN input port through a
// 2-entry FIFO that absorbs RAM latency and backpressure; locks the buffer while busy.
module roi28x28_frame_reader #(
    parameter int unsigned W      = 28,
    parameter int unsigned H      = 28,
    parameter int unsigned ADDR_W = 10,
    parameter bit          INVERT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              frame_ready,
    output logic              buf_lock,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last
);
    localparam int unsigned   N      = W * H;
    localparam int unsigned   CW     = ADDR_W + 1;
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, STREAM, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic            inflight_q, inflight_d;
    logic [1:0][7:0] fifo_q, fifo_d;
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            pop, push;
    logic [7:0]      pix;

    // Next-state, read issue and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        fifo_d     = fifo_q;
        head_d     = head_q;
        tail_d     = tail_q;
        rd_en      = 1'b0;
        push       = 1'b0;
        pop        = m_valid & m_ready;
        pix        = INVERT ? ~rd_data : rd_data;

        case (state_q)
            IDLE: begin
                if (start) state_d = frame_ready ? STREAM : WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (frame_ready) state_d = STREAM;
            end
            STREAM: begin
                push  = inflight_q & ~abort;
                // Reserve a FIFO slot for every outstanding read so it never overflows
                rd_en = ~abort && (rd_cnt_q < N_C) &&
                        ((3'(cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
                if (pop && out_cnt_q == LAST_C) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inflight_d = rd_en;
        if (rd_en) rd_cnt_d = rd_cnt_q + CW'(1);
        if (pop) begin
            head_d    = ~head_q;
            out_cnt_d = out_cnt_q + CW'(1);
        end
        if (push) begin
            fifo_d[tail_q] = pix;
            tail_d         = ~tail_q;
        end
        cnt_d = cnt_q + 2'(push) - 2'(pop);

        if (state_q != STREAM && state_d == STREAM) begin
            rd_cnt_d  = '0;
            out_cnt_d = '0;
        end

        if (abort) begin
            state_d    = IDLE;
            inflight_d = 1'b0;
            cnt_d      = 2'd0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            fifo_q     <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decode directly from registered state
    assign busy     = (state_q == WAIT_FRAME) || (state_q == STREAM);
    assign buf_lock = busy;
    assign done     = (state_q == DONE);
    assign rd_addr  = rd_cnt_q[ADDR_W-1:0];
    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = fifo_q[head_q];
    assign m_last   = m_valid && (out_cnt_q == LAST_C);

endmodule

// File: tb/tb_roi28x28_frame_reader.sv
// Scoreboard bench: two readers (pass-through and inverting) share stimulus;
// expected pixel indices are queued at start and checked at each handshake.
module tb_roi28x28_frame_reader;
    localparam int N = 784;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, abort, frame_ready, m_ready;
    logic       buf_lock0, busy0, done0, rd_en0, m_valid0, m_last0;
    logic       buf_lock1, busy1, done1, rd_en1, m_valid1, m_last1;
    logic [9:0] rd_addr0, rd_addr1;
    logic [7:0] rd_data0, rd_data1, m_data0, m_data1;
    logic [7:0] mem [N];

    int n_chk  = 0;
    int n_pass = 0;
    int hs_cnt = 0;
    int rd_iss = 0;
    int cyc;
    int exp_q[$];

    roi28x28_frame_reader #(.W(28), .H(28), .ADDR_W(10), .INVERT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_ready(frame_ready),
        .buf_lock(buf_lock0), .busy(busy0), .done(done0), .rd_en(rd_en0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .m_valid(m_valid0), .m_ready(m_ready),
        .m_data(m_data0), .m_last(m_last0));

    roi28x28_frame_reader #(.W(28), .H(28), .ADDR_W(10), .INVERT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_ready(frame_ready),
        .buf_lock(buf_lock1), .busy(busy1), .done(done1), .rd_en(rd_en1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .m_data(m_data1), .m_last(m_last1));

    initial forever #5 clk = ~clk;

    always @(posedge clk) if (rd_en0) rd_data0 <= mem[rd_addr0];
    always @(posedge clk) if (rd_en1) rd_data1 <= mem[rd_addr1];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) exp_q.push_back(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        push_frame();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit rand_ready);
        cyc = 0;
        while (!done0 && cyc < 5000) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        m_ready = 1'b1;
        check({name, "_done_seen"}, int'(done0), 1);
        check({name, "_beats"}, hs_cnt, N);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: handshakes against the scoreboard, stall stability, read ordering/occupancy
    initial begin
        bit         stall_prev = 1'b0;
        logic [7:0] stall_data = 8'd0;
        logic       stall_last = 1'b0;
        int         idx;
        logic [7:0] e_inv;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (start && !abort && !busy0 && !done0) begin
                    hs_cnt = 0;
                    rd_iss = 0;
                end
                if (stall_prev) begin
                    check("stall_valid", int'(m_valid0), 1);
                    check("stall_data", int'(m_data0), int'(stall_data));
                    check("stall_last", int'(m_last0), int'(stall_last));
                end
                if (m_valid0 && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        idx   = exp_q.pop_front();
                        e_inv = ~8'(idx);
                        check("m_data", int'(m_data0), idx % 256);
                        check("m_data_inv", int'(m_data1), int'(e_inv));
                        check("m_valid_inv", int'(m_valid1), 1);
                        check("m_last", int'(m_last0), (idx == N - 1) ? 1 : 0);
                    end
                    hs_cnt++;
                end
                if (rd_en0) begin
                    check("rd_addr_seq", int'(rd_addr0), rd_iss);
                    check("rd_addr_range", (int'(rd_addr0) < N) ? 1 : 0, 1);
                    rd_iss++;
                end
                if (rd_en0 || (m_valid0 && m_ready))
                    check("occupancy_le2", (rd_iss - hs_cnt <= 2) ? 1 : 0, 1);
                if (done0) check("done_busy_excl", int'(busy0), 0);
                stall_prev = m_valid0 && !m_ready && !abort;
                stall_data = m_data0;
                stall_last = m_last0;
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        start = 1'b0; abort = 1'b0; frame_ready = 1'b1; m_ready = 1'b1;
        #1 rst = 1'b1;
        #6;
        check("rst_ctrl0", int'({buf_lock0, busy0, done0, rd_en0, m_valid0, m_last0}), 0);
        check("rst_ctrl1", int'({buf_lock1, busy1, done1, rd_en1, m_valid1, m_last1}), 0);
        check("rst_addr", int'(rd_addr0) + int'(rd_addr1), 0);
        check("rst_data", int'(m_data0) + int'(m_data1), 0);
        tick();
        rst = 1'b0;

        // Back-to-back frame with exact latency and completion timing
        pulse_start();
        check("c1_busy", int'(busy0), 1);
        check("c1_lock", int'(buf_lock0), 1);
        check("c1_rd_en", int'(rd_en0), 1);
        check("c1_rd_addr", int'(rd_addr0), 0);
        tick();
        check("c2_m_valid", int'(m_valid0), 0);
        tick();
        check("c3_m_valid", int'(m_valid0), 1);
        check("c3_m_data_inv", int'(m_data1), 255);
        cyc = 3;
        while (!done0 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("done_cycle", cyc, 787);
        check("busy_at_done", int'(busy0), 0);
        check("full_beats", hs_cnt, N);
        tick();
        check("done_pulse_len", int'(done0), 0);
        check("full_queue_empty", exp_q.size(), 0);

        // Random backpressure
        pulse_start();
        wait_done("rand", 1'b1);

        // Frame not yet ready at start
        frame_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            check("wait_busy_lock_rden", int'({busy0, buf_lock0, rd_en0}), 3'b110);
            tick();
        end
        frame_ready = 1'b1;
        check("wait_still_idle_rd", int'(rd_en0), 0);
        tick();
        check("wait_rd_en", int'(rd_en0), 1);
        check("wait_rd_addr", int'(rd_addr0), 0);
        wait_done("wait", 1'b0);

        // Abort after beat 100, then restart
        pulse_start();
        cyc = 0;
        while (hs_cnt != 101 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("abort_beats_before", hs_cnt, 101);
        abort = 1'b1;
        m_ready = 1'b0;
        exp_q.delete();
        tick();
        abort = 1'b0;
        check("abort_m_valid", int'(m_valid0), 0);
        check("abort_busy", int'(busy0), 0);
        check("abort_done", int'(done0), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("abort_quiet", int'({m_valid0, done0, rd_en0}), 0);
        end
        m_ready = 1'b1;
        pulse_start();
        wait_done("restart", 1'b0);

        // Asynchronous reset mid-stream
        pulse_start();
        repeat (50) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", int'({buf_lock0, busy0, done0, rd_en0, m_valid0, m_last0, m_valid1}), 0);
        check("arst_addr", int'(rd_addr0), 0);
        check("arst_data", int'(m_data0) + int'(m_data1), 0);
        exp_q.delete();
        tick();
        rst = 1'b0;

        // Start together with abort does nothing
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("start_abort_quiet", int'({busy0, rd_en0, m_valid0, done0}), 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/roi28x28_frame_reader.md
# roi28x28_frame_reader

Reads the 784-byte (28x28, row-major) grayscale ROI buffer filled by `roi28x28_downsample_writer` and streams it, one pixel per handshake, to the CNN input port. It sits between the ROI buffer's read port and the inference engine. It locks the buffer against overwrite while a frame is in flight, and can optionally invert intensity (dark digit on light paper becomes MNIST-style light digit on dark).

## Interface
Parameters:
- `W`, 28: ROI width in pixels.
- `H`, 28: ROI height in pixels.
- `ADDR_W`, 10: buffer address width; must satisfy 2^ADDR_W >= W*H.
- `INVERT`, 1: 1 means `m_data = ~rd_data`; 0 means pass-through.

Ports:
- `clk`  in  1  Single clock. All logic runs on the rising edge.
- `rst`  in  1  Reset, asynchronous and active-high.
- `start`  in  1  Request to read one frame. Sampled only in IDLE.
- `abort`  in  1  Synchronous cancel. Returns the block to IDLE with no `done`.
- `frame_ready`  in  1  The writer has a complete frame in the buffer.
- `buf_lock`  out  1  High while the buffer is being consumed. The writer must not write while this is high.
- `busy`  out  1  High in WAIT_FRAME and STREAM.
- `done`  out  1  One-cycle pulse after the last pixel handshake.
- `rd_en`  out  1  Buffer read strobe.
- `rd_addr`  out  ADDR_W  Buffer read address.
- `rd_data`  in  8  Buffer data. Valid exactly 1 cycle after `rd_en`.
- `m_valid`  out  1  Output pixel valid.
- `m_ready`  in  1  Consumer ready.
- `m_data`  out  8  Output pixel.
- `m_last`  out  1  High with pixel index W*H-1.

## Operation
- States:
  - IDLE
  - WAIT_FRAME
  - STREAM
  - DONE
- IDLE:
  - `start` with `frame_ready` goes to STREAM.
  - `start` without `frame_ready` goes to WAIT_FRAME.
- WAIT_FRAME: goes to STREAM on the first cycle `frame_ready` is high.
- STREAM: goes to DONE in the cycle after the handshake of the pixel with `m_last`=1.
- DONE: lasts one cycle; `done`=1, then IDLE.
- `abort` in any state goes to IDLE. It flushes the FIFO and discards in-flight reads, so no `m_valid` appears afterwards.
- `buf_lock` = `busy`. `frame_ready` is ignored once in STREAM.
- Read issue: pixel i is read from address i = row*W+col, i = 0..W*H-1, in ascending order.
- Output path: an internal 2-entry FIFO absorbs the 1-cycle RAM latency and backpressure.
- `rd_en` is asserted in STREAM when the read counter is below W*H and (fifo_count + inflight − pop_this_cycle) < 2. Here pop = `m_valid` & `m_ready`. The FIFO therefore never overflows and sustains 1 pixel/cycle.
- `m_valid`, `m_data` and `m_last` are driven from the FIFO head. They are held stable while `m_valid` & !`m_ready`. `m_valid` never drops without a handshake, except on `abort` or `rst`.
- Counters:
  - read counter, ADDR_W+1 bits
  - output counter, ADDR_W+1 bits
  - Both clear on entering STREAM. There is no wrap; reads stop at W*H.
- Simultaneous events:
  - `start` and `abort` in IDLE: `abort` wins, stay IDLE.
  - `abort` and the last handshake in the same cycle: `abort` wins, no `done`.
  - `start` in a non-IDLE state is ignored.

## Timing
- Reset values: `buf_lock`, `busy`, `done`, `rd_en`, `m_valid` and `m_last` are 0; `rd_addr` and `m_data` are 0; FIFO is empty; state is IDLE.
- Latency with `frame_ready`=1 and `start` high in cycle 0:
  - cycle 1: `busy`=`buf_lock`=1, `rd_en`=1, `rd_addr`=0
  - cycle 2: `rd_data` valid
  - cycle 3: `m_valid`=1, `m_data`=f(pixel 0)
- Throughput with `m_ready` held high: one handshake per cycle. Pixel 783 handshakes in cycle 786, `done` is high in cycle 787, and `busy` falls in cycle 787.
- `done` and `busy` are never high together.
- `rst` mid-frame clears all state immediately and asynchronously. The next frame needs a fresh `start`.

## Test plan
- Buffer preloaded with `mem[i]=i[7:0]`, INVERT=0, `start` pulse, `m_ready`=1: 784 beats with `m_data`=i[7:0]; `m_last` only on beat 783 (data 0x0F); `done` 1 cycle after; timing as stated above.
- Same buffer with INVERT=1: beat i carries ~i[7:0]; beat 0 = 0xFF, beat 255 = 0x00.
- Random `m_ready` (50%): the data sequence is identical to the first test; `m_data` is stable during stalls; FIFO count is never above 2; no read is issued past address 783.
- `frame_ready`=0 at `start`: `busy`=`buf_lock`=1 and `rd_en`=0 for 20 cycles. When `frame_ready` is raised, `rd_en` with address 0 follows in the next cycle.
- `abort` after beat 100: next cycle is IDLE, with `m_valid`=0, `busy`=0 and no `done`. A subsequent `start` restarts from pixel 0.
- `rst` asserted mid-stream: all outputs are 0 without waiting for a clock edge. `start` in the same cycle as `abort` produces no activity.
